rf_bank_array: RTL and testbench
================================

// Module: rf_bank_array
// PURPOSE
//  Parametrised banked GPGPU register file: NUM_BANKS independent banks, each with 1 read and 1 write port per cycle.
//  Sits between the operand collectors and the execution writeback path.
//  Each read carries an operand-collector ID (OCID) that returns with the data.
//  Adds over the fixed 4-bank file: per-lane write masks, a valid handshake, and a hardware clear-after-reset sequencer.
// PARAMETERS
//  NUM_BANKS  4   number of banks / channels
//  ADDR_W     3   register address width per bank (depth = 2**ADDR_W)
//  LANES      8   SIMD lanes per register
//  LANE_W     32  bits per lane; DATA_W = LANES*LANE_W
//  OCID_W     3   operand-collector tag width
// PORTS
//  clk         in   1                  clock, all logic on rising edge
//  rst         in   1                  synchronous reset, active-high
//  rd_vld      in   NUM_BANKS          per-bank read request
//  rd_addr     in   NUM_BANKS*ADDR_W   read address, bank b at [b*ADDR_W +: ADDR_W]
//  rd_ocid     in   NUM_BANKS*OCID_W   tag carried with the read
//  wr_en       in   NUM_BANKS          per-bank write enable
//  wr_addr     in   NUM_BANKS*ADDR_W   write address
//  wr_mask     in   NUM_BANKS*LANES    per-lane write enable (1 = write lane)
//  wr_data     in   NUM_BANKS*DATA_W   write data
//  dout_vld    out  NUM_BANKS          read data valid
//  dout        out  NUM_BANKS*DATA_W   read data
//  dout_ocid   out  NUM_BANKS*OCID_W   tag returned with dout
//  init_done   out  1                  clear finished; file accepts traffic
// BEHAVIOUR
//  - Reset: dout_vld=0, dout=0, dout_ocid=0, init_done=0. The FSM enters CLEAR with clr_ptr=0.
//  - FSM CLEAR: each cycle, write all-zero to address clr_ptr in every bank, then clr_ptr++.
//    - When clr_ptr==2**ADDR_W-1 has been written, go to READY (init_done=1 next cycle).
//    - CLEAR lasts exactly 2**ADDR_W cycles after rst falls.
//  - FSM READY: terminal state; only rst leaves it.
//  - rst asserted mid-CLEAR: clr_ptr returns to 0 and CLEAR restarts from the beginning.
//  - While init_done=0: rd_vld and wr_en are ignored; no user write lands; dout_vld stays 0.
//  - Read latency is 1 cycle. rd_vld[b] sampled at cycle N gives, at cycle N+1:
//    - dout_vld[b]=1, dout_ocid[b]=rd_ocid[b], and dout[b] = mem[b][rd_addr[b]].
//  - No rd_vld[b] at N: dout_vld[b]=0 at N+1. dout[b] and dout_ocid[b] hold their previous values.
//  - Back-to-back reads are accepted every cycle. There is no backpressure; the consumer must always accept.
//  - Writes commit at the clock edge. Only lanes with wr_mask bit = 1 change; the other lanes keep their old value.
//  - wr_en with wr_mask=0 leaves memory unchanged.
//  - Banks are fully independent: no cross-bank conflicts, and all NUM_BANKS banks may read and write in the same cycle.
//  - Same-bank read and write to the same address in the same cycle: the result depends on the
//    configuration below. Different addresses never interact.
//  - Widths: addresses are used unsigned with no wrap logic needed (range is exactly the depth).
//    OCID is passed through unmodified.
// CONFIGURATION
//  RF_WRITE_BYPASS_EN
//    defined: write-first. A same-cycle, same-address read returns the merged word
//      (new data on masked lanes, old data elsewhere).
//    undefined: read-first. A same-cycle, same-address read returns the old contents.
//      The new data is visible to reads issued from the next cycle on.
// TESTING
//  1. Clear sequence: rst for 2 cycles, then release.
//     -> init_done rises exactly 2**ADDR_W cycles later (8 at default).
//     -> A read of every address in every bank returns 0.
//  2. Reset mid-clear: pulse rst at CLEAR cycle 5.
//     -> init_done is delayed to 8 cycles after the second release.
//     -> A write attempted during CLEAR is absent afterwards.
//  3. Masked write: bank2 addr3, write all-ones with mask=8'hFF; then write 0 with mask=8'h0F; then read.
//     -> dout lanes 0-3 = 0, lanes 4-7 = 32'hFFFFFFFF, dout_ocid = the issued tag, dout_vld for exactly 1 cycle.
//  4. Collision: bank0 addr1 holds A. In the same cycle, write B (full mask) and read addr1.
//     -> With the macro: the read returns B.
//     -> Without the macro: the read returns A, and the next-cycle read returns B.
//  5. Parallel streaming: all 4 banks, reads every cycle for 16 cycles with distinct OCIDs and addresses.
//     -> Each dout/ocid pair matches 1 cycle later, in order, with no bubbles.
//  6. Bank isolation: write bank1 addr5 = C.
//     -> A read of addr5 in banks 0, 2 and 3 returns their prior values; bank1 returns C.

Source files
------------

// File: rtl/rf_bank_array.sv
// Banked register file with per-lane masked writes and a zeroing sequencer after reset; 1-cycle reads, no backpressure.
// RF_WRITE_BYPASS_EN selects write-first (merged word) for a same-cycle same-address read; the default is read-first.
module rf_bank_array #(
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 3,
    parameter int LANES     = 8,
    parameter int LANE_W    = 32,
    parameter int OCID_W    = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_BANKS-1:0]          rd_vld,
    input  logic [NUM_BANKS*ADDR_W-1:0]   rd_addr,
    input  logic [NUM_BANKS*OCID_W-1:0]   rd_ocid,
    input  logic [NUM_BANKS-1:0]          wr_en,
    input  logic [NUM_BANKS*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_BANKS*LANES-1:0]    wr_mask,
    input  logic [NUM_BANKS*LANES*LANE_W-1:0] wr_data,
    output logic [NUM_BANKS-1:0]          dout_vld,
    output logic [NUM_BANKS*LANES*LANE_W-1:0] dout,
    output logic [NUM_BANKS*OCID_W-1:0]   dout_ocid,
    output logic                          init_done
);

    localparam int DATA_W = LANES * LANE_W;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   clr_ptr;
    logic                ready;
    logic                clr_we;

    logic [DATA_W-1:0]   mem [NUM_BANKS][DEPTH];

    logic [ADDR_W-1:0]   ra       [NUM_BANKS];
    logic [ADDR_W-1:0]   wa       [NUM_BANKS];
    logic [DATA_W-1:0]   wr_word  [NUM_BANKS];
    logic [DATA_W-1:0]   rd_word  [NUM_BANKS];
    logic [NUM_BANKS-1:0] user_we;
    logic [NUM_BANKS-1:0] user_re;

    assign ready     = (state == ST_READY);
    assign init_done = ready;
    assign clr_we    = (state == ST_CLEAR) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (clr_ptr == {ADDR_W{1'b1}}) state_nxt = ST_READY;
            ST_READY: state_nxt = ST_READY;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_ptr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
        end
    end

    // Merged word = old contents with the masked lanes replaced; also feeds the bypass path.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            ra[b]      = rd_addr[b*ADDR_W +: ADDR_W];
            wa[b]      = wr_addr[b*ADDR_W +: ADDR_W];
            user_we[b] = wr_en[b] && ready && !rst;
            user_re[b] = rd_vld[b] && ready;
            wr_word[b] = mem[b][wa[b]];
            for (int l = 0; l < LANES; l++) begin
                if (wr_mask[b*LANES + l]) begin
                    wr_word[b][l*LANE_W +: LANE_W] = wr_data[b*DATA_W + l*LANE_W +: LANE_W];
                end
            end
            rd_word[b] = mem[b][ra[b]];
`ifdef RF_WRITE_BYPASS_EN
            if (user_we[b] && (wa[b] == ra[b])) begin
                rd_word[b] = wr_word[b];
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (clr_we) begin
                mem[b][clr_ptr] <= '0;
            end else if (user_we[b]) begin
                mem[b][wa[b]] <= wr_word[b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_vld  <= '0;
            dout      <= '0;
            dout_ocid <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                dout_vld[b] <= user_re[b];
                if (user_re[b]) begin
                    dout[b*DATA_W +: DATA_W]      <= rd_word[b];
                    dout_ocid[b*OCID_W +: OCID_W] <= rd_ocid[b*OCID_W +: OCID_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_bank_array.sv
// Randomized and directed bench for rf_bank_array against an array-based reference model.
module tb_rf_bank_array;

    localparam int NB    = 4;
    localparam int AW    = 3;
    localparam int LN    = 8;
    localparam int LW    = 32;
    localparam int OW    = 3;
    localparam int DW    = LN * LW;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NB-1:0]       rd_vld;
    logic [NB*AW-1:0]    rd_addr;
    logic [NB*OW-1:0]    rd_ocid;
    logic [NB-1:0]       wr_en;
    logic [NB*AW-1:0]    wr_addr;
    logic [NB*LN-1:0]    wr_mask;
    logic [NB*DW-1:0]    wr_data;
    logic [NB-1:0]       dout_vld;
    logic [NB*DW-1:0]    dout;
    logic [NB*OW-1:0]    dout_ocid;
    logic                init_done;

    rf_bank_array #(
        .NUM_BANKS(NB), .ADDR_W(AW), .LANES(LN), .LANE_W(LW), .OCID_W(OW)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_vld(rd_vld), .rd_addr(rd_addr), .rd_ocid(rd_ocid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
        .dout_vld(dout_vld), .dout(dout), .dout_ocid(dout_ocid),
        .init_done(init_done)
    );

    logic [DW-1:0] mem_m    [NB][DEPTH];
    logic [DW-1:0] exp_dout [NB];
    logic [OW-1:0] exp_ocid [NB];
    logic [NB-1:0] exp_vld;
    bit            ready_m;
    int            clr_cnt;
    int            n_chk;
    int            n_fail;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [LN-1:0] m);
        logic [DW-1:0] r;
        r = old_w;
        for (int l = 0; l < LN; l++) if (m[l]) r[l*LW +: LW] = new_w[l*LW +: LW];
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int l = 0; l < LN; l++) w[l*LW +: LW] = $urandom;
        return w;
    endfunction

    task automatic idle();
        rd_vld = '0; rd_addr = '0; rd_ocid = '0;
        wr_en = '0; wr_addr = '0; wr_mask = '0; wr_data = '0;
    endtask

    task automatic set_rd(input int b, input int a, input int tag);
        rd_vld[b] = 1'b1;
        rd_addr[b*AW +: AW] = AW'(a);
        rd_ocid[b*OW +: OW] = OW'(tag);
    endtask

    task automatic set_wr(input int b, input int a, input logic [LN-1:0] m, input logic [DW-1:0] d);
        wr_en[b] = 1'b1;
        wr_addr[b*AW +: AW] = AW'(a);
        wr_mask[b*LN +: LN] = m;
        wr_data[b*DW +: DW] = d;
    endtask

    // Model the effect of the current inputs, clock once, then compare every output.
    task automatic tick();
        int ra;
        int wa;
        logic [DW-1:0] rdw;
        if (rst) begin
            ready_m = 1'b0;
            clr_cnt = 0;
            exp_vld = '0;
            for (int b = 0; b < NB; b++) begin
                exp_dout[b] = '0;
                exp_ocid[b] = '0;
            end
        end else if (!ready_m) begin
            exp_vld = '0;
            for (int b = 0; b < NB; b++) mem_m[b][clr_cnt] = '0;
            clr_cnt++;
            if (clr_cnt == DEPTH) ready_m = 1'b1;
        end else begin
            for (int b = 0; b < NB; b++) begin
                ra = int'(rd_addr[b*AW +: AW]);
                wa = int'(wr_addr[b*AW +: AW]);
                exp_vld[b] = rd_vld[b];
                if (rd_vld[b]) begin
                    rdw = mem_m[b][ra];
`ifdef RF_WRITE_BYPASS_EN
                    if (wr_en[b] && wa == ra)
                        rdw = merge(rdw, wr_data[b*DW +: DW], wr_mask[b*LN +: LN]);
`endif
                    exp_dout[b] = rdw;
                    exp_ocid[b] = rd_ocid[b*OW +: OW];
                end
                if (wr_en[b])
                    mem_m[b][wa] = merge(mem_m[b][wa], wr_data[b*DW +: DW], wr_mask[b*LN +: LN]);
            end
        end
        @(posedge clk);
        #1;
        chk("init_done", DW'(init_done), DW'(ready_m));
        for (int b = 0; b < NB; b++) begin
            chk($sformatf("dout_vld[%0d]", b), DW'(dout_vld[b]), DW'(exp_vld[b]));
            chk($sformatf("dout[%0d]", b), dout[b*DW +: DW], exp_dout[b]);
            chk($sformatf("dout_ocid[%0d]", b), DW'(dout_ocid[b*OW +: OW]), DW'(exp_ocid[b]));
        end
    endtask

    logic [DW-1:0] val_a;
    logic [DW-1:0] val_b;
    logic [DW-1:0] val_c;
    logic [DW-1:0] half_ones;
    logic [DW-1:0] prior [NB];
    int            lat;

    initial begin
        n_chk = 0;
        n_fail = 0;
        ready_m = 1'b0;
        clr_cnt = 0;
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < DEPTH; a++) mem_m[b][a] = '0;
        idle();

        // Clear sequence after a 2-cycle reset.
        rst = 1'b1;
        tick();
        chk("rst_dout_vld", DW'(dout_vld), '0);
        chk("rst_dout", dout[DW-1:0], '0);
        chk("rst_init_done", DW'(init_done), '0);
        tick();
        rst = 1'b0;
        lat = 0;
        while (!init_done && lat < 20) begin
            tick();
            lat++;
        end
        chk("clear_latency", DW'(lat), DW'(DEPTH));
        for (int a = 0; a < DEPTH; a++) begin
            idle();
            for (int b = 0; b < NB; b++) set_rd(b, a, a);
            tick();
            for (int b = 0; b < NB; b++) chk("clear_zero", dout[b*DW +: DW], '0);
        end
        idle();

        // Reset in the middle of CLEAR, with a user write attempted during CLEAR.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i == 3) set_wr(0, 0, 8'hFF, {DW{1'b1}});
            tick();
        end
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lat = 0;
        while (!init_done && lat < 20) begin
            tick();
            lat++;
        end
        chk("reclear_latency", DW'(lat), DW'(DEPTH));
        set_rd(0, 0, 4);
        tick();
        chk("clear_write_dropped", dout[DW-1:0], '0);
        idle();

        // Masked write into bank2 addr3.
        set_wr(2, 3, 8'hFF, {DW{1'b1}});
        tick();
        idle();
        set_wr(2, 3, 8'h0F, '0);
        tick();
        idle();
        set_rd(2, 3, 5);
        tick();
        half_ones = {{(DW/2){1'b1}}, {(DW/2){1'b0}}};
        chk("mask_data", dout[2*DW +: DW], half_ones);
        chk("mask_ocid", DW'(dout_ocid[2*OW +: OW]), DW'(5));
        chk("mask_vld_on", DW'(dout_vld[2]), DW'(1));
        idle();
        tick();
        chk("mask_vld_off", DW'(dout_vld[2]), DW'(0));

        // Same-cycle same-address collision on bank0 addr1.
        val_a = rand_word();
        val_b = ~val_a;
        set_wr(0, 1, 8'hFF, val_a);
        tick();
        idle();
        set_wr(0, 1, 8'hFF, val_b);
        set_rd(0, 1, 1);
        tick();
`ifdef RF_WRITE_BYPASS_EN
        chk("collide_same_cycle", dout[DW-1:0], val_b);
`else
        chk("collide_same_cycle", dout[DW-1:0], val_a);
`endif
        idle();
        set_rd(0, 1, 2);
        tick();
        chk("collide_next_cycle", dout[DW-1:0], val_b);
        idle();

        // Parallel streaming on all banks.
        for (int i = 0; i < 16; i++) begin
            idle();
            for (int b = 0; b < NB; b++) set_rd(b, (i + b) % DEPTH, (i + 2 * b) % 8);
            tick();
        end
        idle();

        // Bank isolation: bank1 addr5 written, other banks untouched.
        val_c = rand_word();
        for (int b = 0; b < NB; b++) prior[b] = mem_m[b][5];
        set_wr(1, 5, 8'hFF, val_c);
        tick();
        idle();
        for (int b = 0; b < NB; b++) set_rd(b, 5, b);
        tick();
        chk("iso_bank1", dout[1*DW +: DW], val_c);
        chk("iso_bank0", dout[0*DW +: DW], prior[0]);
        chk("iso_bank2", dout[2*DW +: DW], prior[2]);
        chk("iso_bank3", dout[3*DW +: DW], prior[3]);
        idle();

        // Random traffic, including same-address collisions and partial masks.
        for (int i = 0; i < 300; i++) begin
            idle();
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, 3) != 0) set_rd(b, $urandom_range(0, 7), $urandom_range(0, 7));
                if ($urandom_range(0, 1) != 0)
                    set_wr(b, $urandom_range(0, 7), LN'($urandom), rand_word());
            end
            tick();
        end
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
